// File: rtl/tree_node_dispatch.sv
// Fans one valid/ready request stream out to NUM_CHILD independent child FIFOs.
// Define TREE_NODE_BCAST_EN to make an all-ones in_dest a broadcast to every child.
`timescale 1ns/1ps
module tree_node_dispatch #(
    parameter int NUM_CHILD  = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int DEST_W    = $clog2(NUM_CHILD + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DEST_W-1:0]             in_dest,
    input  logic [DATA_W-1:0]             in_data,
    output logic [NUM_CHILD-1:0]          out_valid,
    input  logic [NUM_CHILD-1:0]          out_ready,
    output logic [NUM_CHILD*DATA_W-1:0]   out_data,
    output logic                          err_bad_dest,
    output logic [15:0]                   drop_cnt,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]    mem        [NUM_CHILD][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr     [NUM_CHILD];
    logic [PTR_W-1:0]     rd_ptr     [NUM_CHILD];
    logic [CNT_W-1:0]     count      [NUM_CHILD];
    logic [CNT_W-1:0]     count_next [NUM_CHILD];

    logic [NUM_CHILD-1:0] full;
    logic [NUM_CHILD-1:0] empty;
    logic [NUM_CHILD-1:0] push;
    logic [NUM_CHILD-1:0] pop;

    logic dest_valid;
    logic is_bcast;
    logic sel_full;
    logic handshake;
    logic drop;
    logic busy_next;

    // Fullness comes from registered occupancy only, so in_ready never sees out_ready.
    always_comb begin
        full  = '0;
        empty = '0;
        pop   = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
            empty[i] = (count[i] == '0);
            pop[i]   = !empty[i] && out_ready[i];
        end
    end

    always_comb begin
        dest_valid = (in_dest < DEST_W'(NUM_CHILD));
        sel_full   = 1'b0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (in_dest == DEST_W'(i)) begin
                sel_full = full[i];
            end
        end
`ifdef TREE_NODE_BCAST_EN
        is_bcast = &in_dest;
        if (is_bcast) begin
            in_ready = ~|full;
        end else if (dest_valid) begin
            in_ready = !sel_full;
        end else begin
            in_ready = 1'b1;
        end
`else
        is_bcast = 1'b0;
        in_ready = dest_valid ? !sel_full : 1'b1;
`endif
        handshake = in_valid && in_ready && !rst;
        drop      = handshake && !dest_valid && !is_bcast;
        push      = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            push[i] = handshake && (is_bcast || (in_dest == DEST_W'(i)));
        end
    end

    // Simultaneous push and pop leave occupancy unchanged.
    always_comb begin
        busy_next = 1'b0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            count_next[i] = count[i];
            if (push[i] && !pop[i]) begin
                count_next[i] = count[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                count_next[i] = count[i] - CNT_W'(1);
            end
            if (count_next[i] != '0) begin
                busy_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHILD; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            err_bad_dest <= 1'b0;
            drop_cnt     <= '0;
            busy         <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHILD; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count_next[i];
            end
            err_bad_dest <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            busy <= busy_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data;
            end
        end
    end

    assign out_valid = ~empty;

    for (genvar g = 0; g < NUM_CHILD; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = mem[g][rd_ptr[g]];
    end

endmodule
